// File: rtl/tmds_decoder_ch.sv
// Receive-side TMDS channel: word alignment by bit-slip hunting on control-token runs, then
// 2-stage classify/decode of 10-bit symbols. Optional statistics counters under DECODE_STATS_EN.
module tmds_decoder_ch #(
    parameter int unsigned CTRL_RUN     = 32'd16,
    parameter int unsigned HUNT_TIMEOUT = 32'd64,
    parameter int unsigned SLIP_WAIT    = 32'd8,
    parameter int unsigned MAX_GAP      = 32'd4096
) (
    input  logic       clk_pix,
    input  logic       rst_n_pix,
    input  logic [9:0] sym_in,
    input  logic       sym_valid,
    output logic       bitslip,
    output logic       locked,
    output logic       out_valid,
    output logic       de,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic [7:0] slip_count,
    output logic [7:0] lock_losses
);

    localparam int RUN_W  = $clog2(CTRL_RUN + 32'd1);
    localparam int TO_W   = $clog2(HUNT_TIMEOUT + 32'd1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 32'd1);
    localparam int GAP_W  = $clog2(MAX_GAP + 32'd1);

    localparam logic [RUN_W-1:0]  RUN_END   = RUN_W'(CTRL_RUN);
    localparam logic [TO_W-1:0]   TO_END    = TO_W'(HUNT_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_END  = WAIT_W'(SLIP_WAIT);
    localparam logic [GAP_W-1:0]  GAP_END   = GAP_W'(MAX_GAP);
    localparam logic [RUN_W-1:0]  RUN_ONE   = {{(RUN_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]   TO_ONE    = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0]  GAP_ONE   = {{(GAP_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SLIP   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // Returns {is_token, c1, c0}.
    function automatic logic [2:0] classify(input logic [9:0] s);
        logic [2:0] r;
        case (s)
            10'h354: r = 3'b100;
            10'h0AB: r = 3'b101;
            10'h154: r = 3'b110;
            10'h2AB: r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] d;
        logic [7:0] q;
        d    = s[9] ? ~s[7:0] : s[7:0];
        q    = 8'h00;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return q;
    endfunction

    state_t            state_r, state_next;
    logic [RUN_W-1:0]  run_r, run_next;
    logic [TO_W-1:0]   to_r, to_next;
    logic [WAIT_W-1:0] wait_r, wait_next;
    logic [GAP_W-1:0]  gap_r, gap_next;

    logic [2:0]        cls_s;
    logic              tok_s;
    logic [RUN_W-1:0]  run_inc_s;
    logic [TO_W-1:0]   to_inc_s;
    logic [WAIT_W-1:0] wait_inc_s;
    logic [GAP_W-1:0]  gap_inc_s;

    logic              v1_r;
    logic              tok1_r;
    logic [1:0]        ctrl1_r;
    logic [9:0]        sym1_r;

    assign cls_s      = classify(sym_in);
    assign tok_s      = cls_s[2];
    assign run_inc_s  = run_r + RUN_ONE;
    assign to_inc_s   = to_r + TO_ONE;
    assign wait_inc_s = wait_r + WAIT_ONE;
    assign gap_inc_s  = gap_r + GAP_ONE;

    // Alignment FSM state and counters.
    always_ff @(posedge clk_pix or negedge rst_n_pix) begin
        if (!rst_n_pix) begin
            state_r <= ST_HUNT;
            run_r   <= {RUN_W{1'b0}};
            to_r    <= {TO_W{1'b0}};
            wait_r  <= {WAIT_W{1'b0}};
            gap_r   <= {GAP_W{1'b0}};
            locked  <= 1'b0;
            bitslip <= 1'b0;
        end else begin
            state_r <= state_next;
            run_r   <= run_next;
            to_r    <= to_next;
            wait_r  <= wait_next;
            gap_r   <= gap_next;
            locked  <= (state_next == ST_LOCKED);
            bitslip <= (state_next == ST_SLIP);
        end
    end

    // Alignment FSM next-state; only valid symbols advance the counters.
    always_comb begin
        state_next = state_r;
        run_next   = run_r;
        to_next    = to_r;
        wait_next  = wait_r;
        gap_next   = gap_r;
        case (state_r)
            ST_HUNT: begin
                if (sym_valid) begin
                    to_next = to_inc_s;
                    if (tok_s) begin
                        run_next = run_inc_s;
                    end else begin
                        run_next = {RUN_W{1'b0}};
                    end
                    // A completed token run takes priority over a coincident timeout.
                    if (tok_s && (run_inc_s == RUN_END)) begin
                        state_next = ST_LOCKED;
                        gap_next   = {GAP_W{1'b0}};
                    end else if (to_inc_s == TO_END) begin
                        state_next = ST_SLIP;
                    end else begin
                        state_next = ST_HUNT;
                    end
                end else begin
                    state_next = ST_HUNT;
                end
            end
            ST_SLIP: begin
                state_next = ST_WAIT;
                wait_next  = {WAIT_W{1'b0}};
            end
            ST_WAIT: begin
                if (sym_valid && (wait_inc_s == WAIT_END)) begin
                    state_next = ST_HUNT;
                    run_next   = {RUN_W{1'b0}};
                    to_next    = {TO_W{1'b0}};
                end else if (sym_valid) begin
                    wait_next = wait_inc_s;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_LOCKED: begin
                if (sym_valid && tok_s) begin
                    gap_next = {GAP_W{1'b0}};
                end else if (sym_valid && (gap_inc_s == GAP_END)) begin
                    state_next = ST_HUNT;
                    run_next   = {RUN_W{1'b0}};
                    to_next    = {TO_W{1'b0}};
                    gap_next   = {GAP_W{1'b0}};
                end else if (sym_valid) begin
                    gap_next = gap_inc_s;
                end else begin
                    state_next = ST_LOCKED;
                end
            end
            default: begin
                state_next = ST_HUNT;
                run_next   = {RUN_W{1'b0}};
                to_next    = {TO_W{1'b0}};
                wait_next  = {WAIT_W{1'b0}};
                gap_next   = {GAP_W{1'b0}};
            end
        endcase
    end

    // Stage 1: classify the incoming symbol.
    always_ff @(posedge clk_pix or negedge rst_n_pix) begin
        if (!rst_n_pix) begin
            v1_r    <= 1'b0;
            tok1_r  <= 1'b0;
            ctrl1_r <= 2'b00;
            sym1_r  <= 10'h000;
        end else begin
            v1_r <= sym_valid;
            if (sym_valid) begin
                tok1_r  <= tok_s;
                ctrl1_r <= cls_s[1:0];
                sym1_r  <= sym_in;
            end
        end
    end

    // Stage 2: decode; de is gated by the lock state at the time of output.
    always_ff @(posedge clk_pix or negedge rst_n_pix) begin
        if (!rst_n_pix) begin
            out_valid <= 1'b0;
            de        <= 1'b0;
            data      <= 8'h00;
            ctrl      <= 2'b00;
        end else begin
            out_valid <= v1_r;
            if (v1_r && tok1_r) begin
                de   <= 1'b0;
                ctrl <= ctrl1_r;
            end else if (v1_r) begin
                de   <= locked;
                data <= tmds_decode(sym1_r);
            end
        end
    end

`ifdef DECODE_STATS_EN
    // Saturating slip and lock-loss statistics; cleared only by reset.
    always_ff @(posedge clk_pix or negedge rst_n_pix) begin
        if (!rst_n_pix) begin
            slip_count  <= 8'h00;
            lock_losses <= 8'h00;
        end else begin
            if ((state_next == ST_SLIP) && (slip_count != 8'hFF)) begin
                slip_count <= slip_count + 8'h01;
            end
            if ((state_r == ST_LOCKED) && (state_next == ST_HUNT) && (lock_losses != 8'hFF)) begin
                lock_losses <= lock_losses + 8'h01;
            end
        end
    end
`else
    assign slip_count  = 8'h00;
    assign lock_losses = 8'h00;
`endif

endmodule

// File: tb/tb_tmds_decoder_ch.sv
// Scoreboard bench for tmds_decoder_ch: expected outputs are queued per driven symbol and
// popped as out_valid appears; lock, slip and out_valid timing are checked every cycle.
module tb_tmds_decoder_ch;

    logic       clk_pix = 1'b0;
    logic       rst_n_pix;
    logic [9:0] sym_in;
    logic       sym_valid;
    logic       bitslip;
    logic       locked;
    logic       out_valid;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic [7:0] slip_count;
    logic [7:0] lock_losses;

`ifdef DECODE_STATS_EN
    localparam logic [7:0] EXP_SLIPS = 8'd3;
    localparam logic [7:0] EXP_LOSS  = 8'd1;
`else
    localparam logic [7:0] EXP_SLIPS = 8'd0;
    localparam logic [7:0] EXP_LOSS  = 8'd0;
`endif

    tmds_decoder_ch dut (
        .clk_pix     (clk_pix),
        .rst_n_pix   (rst_n_pix),
        .sym_in      (sym_in),
        .sym_valid   (sym_valid),
        .bitslip     (bitslip),
        .locked      (locked),
        .out_valid   (out_valid),
        .de          (de),
        .data        (data),
        .ctrl        (ctrl),
        .slip_count  (slip_count),
        .lock_losses (lock_losses)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       de_chk;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad   = 0;
    bit         use_model;
    logic       m_lk;
    int         m_run;
    int         m_gap;
    logic [7:0] m_data;
    logic [1:0] m_ctrl;
    logic [1:0] vhist;
    int         off;
    int         nslip;
    int         lock_at;
    int         slip_at [3];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_decode(input logic [9:0] s);
        logic [7:0] d;
        logic [7:0] x;
        logic [7:0] q;
        d    = s[9] ? ~s[7:0] : s[7:0];
        x    = d ^ {d[6:0], 1'b0};
        q    = s[8] ? x : ~x;
        q[0] = d[0];
        return q;
    endfunction

    function automatic int tok_code(input logic [9:0] s);
        if (s == 10'h354) return 0;
        if (s == 10'h0AB) return 1;
        if (s == 10'h154) return 2;
        if (s == 10'h2AB) return 3;
        return -1;
    endfunction

    function automatic logic [9:0] rot(input logic [9:0] w, input int k);
        logic [19:0] ww;
        ww = {w, w};
        ww = ww << k;
        return ww[19:10];
    endfunction

    task automatic model_step(input logic [9:0] s);
        int   c;
        exp_t e;
        c = tok_code(s);
        if (use_model) begin
            if (!m_lk) begin
                m_run = (c >= 0) ? m_run + 1 : 0;
                if (m_run == 16) begin
                    m_lk  = 1'b1;
                    m_gap = 0;
                end
            end else begin
                m_gap = (c >= 0) ? 0 : m_gap + 1;
                if (m_gap == 4096) begin
                    m_lk  = 1'b0;
                    m_run = 0;
                    m_gap = 0;
                end
            end
        end
        if (c >= 0) m_ctrl = 2'(c);
        else        m_data = ref_decode(s);
        e.de     = (c < 0) && m_lk;
        e.data   = m_data;
        e.ctrl   = m_ctrl;
        e.de_chk = use_model;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [9:0] s, input logic v);
        sym_in    = s;
        sym_valid = v;
        if (v) model_step(s);
        vhist = {vhist[0], v};
        @(negedge clk_pix);
        chk("out_valid", 16'(out_valid), 16'(vhist[1]));
        if (use_model) begin
            chk("locked", 16'(locked), 16'(m_lk));
            chk("bitslip_idle", 16'(bitslip), 16'(1'b0));
        end
    endtask

    task automatic do_reset();
        sym_valid = 1'b0;
        sym_in    = 10'h000;
        rst_n_pix = 1'b0;
        repeat (3) @(negedge clk_pix);
        rst_n_pix = 1'b1;
        sb.delete();
        vhist  = 2'b00;
        m_lk   = 1'b0;
        m_run  = 0;
        m_gap  = 0;
        m_data = 8'h00;
        m_ctrl = 2'b00;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"},  16'(locked),      16'h0000);
        chk({tag, "_ovalid"},  16'(out_valid),   16'h0000);
        chk({tag, "_de"},      16'(de),          16'h0000);
        chk({tag, "_data"},    16'(data),        16'h0000);
        chk({tag, "_ctrl"},    16'(ctrl),        16'h0000);
        chk({tag, "_bitslip"}, 16'(bitslip),     16'h0000);
        chk({tag, "_slips"},   16'(slip_count),  16'h0000);
        chk({tag, "_losses"},  16'(lock_losses), 16'h0000);
    endtask

    // Scoreboard consumer: one queued expectation per out_valid.
    always @(negedge clk_pix) begin
        if (rst_n_pix === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 16'(out_valid), 16'h0000);
            end else begin
                mon_e = sb.pop_front();
                chk("data", 16'(data), 16'(mon_e.data));
                chk("ctrl", 16'(ctrl), 16'(mon_e.ctrl));
                if (mon_e.de_chk) chk("de", 16'(de), 16'(mon_e.de));
            end
        end
    end

    initial begin
        use_model = 1'b1;
        do_reset();
        chk_all_zero("reset");

        // Token run to lock, then asynchronous mid-run reset and relock.
        repeat (20) drive(10'h354, 1'b1);
        chk("t1_locked", 16'(locked), 16'h0001);
        #2 rst_n_pix = 1'b0;
        #1 chk_all_zero("t1_async");
        do_reset();
        repeat (15) drive(10'h354, 1'b1);
        chk("t1_relock_early", 16'(locked), 16'h0000);
        drive(10'h354, 1'b1);
        chk("t1_relock", 16'(locked), 16'h0001);

        // Lock on 2AB, then two data symbols.
        do_reset();
        repeat (16) drive(10'h2AB, 1'b1);
        drive(10'h1FF, 1'b1);
        drive(10'h100, 1'b1);
        repeat (3) drive(10'h000, 1'b0);
        chk("t2_data", 16'(data), 16'h0000);
        chk("t2_de",   16'(de),   16'h0001);
        chk("t2_ctrl", 16'(ctrl), 16'h0003);
        chk("t2_drain", 16'(sb.size()), 16'h0000);

        // Stream rotated by 3 bits; the deserializer model slips one bit per pulse.
        do_reset();
        use_model = 1'b0;
        off = 3;
        nslip = 0;
        lock_at = 0;
        for (int i = 0; i < 400 && lock_at == 0; i++) begin
            drive(rot(10'h354, off), 1'b1);
            if (bitslip) begin
                if (nslip < 3) slip_at[nslip] = i + 1;
                nslip++;
                if (off > 0) off--;
            end
            if (locked && lock_at == 0) lock_at = i + 1;
        end
        chk("t3_nslip", 16'(nslip), 16'd3);
        chk("t3_slip1", 16'(slip_at[0]), 16'd64);
        chk("t3_gap1",  16'(slip_at[1] - slip_at[0]), 16'd73);
        chk("t3_gap2",  16'(slip_at[2] - slip_at[1]), 16'd73);
        chk("t3_lock_at", 16'(lock_at), 16'd235);
        chk("t3_slip_count", 16'(slip_count), 16'(EXP_SLIPS));
        do_reset();
        use_model = 1'b1;

        // Gap timeout: 4096 data symbols drop lock.
        repeat (16) drive(10'h2AB, 1'b1);
        for (int i = 1; i <= 4095; i++) drive(10'h1FF, 1'b1);
        chk("t4_before_drop", 16'(locked), 16'h0001);
        drive(10'h1FF, 1'b1);
        chk("t4_drop", 16'(locked), 16'h0000);
        repeat (4) drive(10'h1FF, 1'b1);
        chk("t4_de_after", 16'(de), 16'h0000);
        chk("t4_losses", 16'(lock_losses), 16'(EXP_LOSS));

        // One token at symbol 4000 keeps lock.
        do_reset();
        repeat (16) drive(10'h2AB, 1'b1);
        for (int i = 1; i <= 4096; i++) drive((i == 4000) ? 10'h354 : 10'h1FF, 1'b1);
        chk("t4_hold", 16'(locked), 16'h0001);
        chk("t4_hold_losses", 16'(lock_losses), 16'h0000);

        // sym_valid gaps inside the token run.
        do_reset();
        repeat (8) drive(10'h354, 1'b1);
        repeat (5) drive(10'h354, 1'b0);
        repeat (7) drive(10'h354, 1'b1);
        chk("t5_early", 16'(locked), 16'h0000);
        drive(10'h354, 1'b1);
        chk("t5_lock", 16'(locked), 16'h0001);
        repeat (3) drive(10'h000, 1'b0);
        chk("t5_drain", 16'(sb.size()), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
